// File: rtl/xintf_regbank_if.sv
// xintf_regbank_if: DSP external-interface bus (strobes, address, data pads).
// The DSP side drives the strobes/address/data-in; the register bank drives data-out and the pad enable.
`timescale 1ns/1ps
`default_nettype none

interface xintf_regbank_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] xadd;
  logic [DATA_W-1:0] xdata_in;
  logic [DATA_W-1:0] xdata_out;
  logic              xdata_oe;

  modport master (
    output ren, wen, xadd, xdata_in,
    input  xdata_out, xdata_oe
  );

  modport slave (
    input  ren, wen, xadd, xdata_in,
    output xdata_out, xdata_oe
  );
endinterface

`default_nettype wire

// File: rtl/xintf_regbank.sv
// +--------------------------------------------------------------------------+
// | Module   : xintf_regbank                                                 |
// | Purpose  : DSP XINTF register bank; synchronised strobes, read channels  |
// |            snapshot to the pad, write channels with one-cycle pulses.    |
// | Options  : define XINTF_WR_READBACK_EN to allow reads of the WR window.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module xintf_regbank #(
  parameter int                NUM_RD  = 4,
  parameter int                NUM_WR  = 4,
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 20,
  parameter logic [ADDR_W-1:0] RD_BASE = 20'h0FC01,
  parameter logic [ADDR_W-1:0] WR_BASE = 20'h0FC05
) (
  input  wire logic                     clk,
  input  wire logic                     global_rst,
  xintf_regbank_if.slave                bus,
  input  wire logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic      [NUM_WR*DATA_W-1:0] wr_data,
  output logic      [NUM_WR-1:0]        wr_pulse,
  output logic      [7:0]               bad_addr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic              r_ren_q1, r_ren_q2, r_ren_q3;
  logic              r_wen_q1, r_wen_q2, r_wen_q3;
  logic [ADDR_W-1:0] r_xadd_q1, r_xadd_q2, r_xadd_q3;
  logic [DATA_W-1:0] r_din_q1, r_din_q2, r_din_q3;
  logic [1:0]        r_settle;
  logic              r_wen_arm;

  state_t                    r_state;
  logic [DATA_W-1:0]         r_xdata_out;
  logic                      r_xdata_oe;
  logic [NUM_WR*DATA_W-1:0]  r_wr_data;
  logic [NUM_WR-1:0]         r_wr_pulse;
  logic [7:0]                r_bad_cnt;

  always_ff @(posedge clk) begin
    if (global_rst) begin
      r_ren_q1  <= 1'b1;  r_ren_q2  <= 1'b1;  r_ren_q3  <= 1'b1;
      r_wen_q1  <= 1'b1;  r_wen_q2  <= 1'b1;  r_wen_q3  <= 1'b1;
      r_xadd_q1 <= '0;    r_xadd_q2 <= '0;    r_xadd_q3 <= '0;
      r_din_q1  <= '0;    r_din_q2  <= '0;    r_din_q3  <= '0;
    end else begin
      r_ren_q1  <= bus.ren;      r_ren_q2  <= r_ren_q1;   r_ren_q3  <= r_ren_q2;
      r_wen_q1  <= bus.wen;      r_wen_q2  <= r_wen_q1;   r_wen_q3  <= r_wen_q2;
      r_xadd_q1 <= bus.xadd;     r_xadd_q2 <= r_xadd_q1;  r_xadd_q3 <= r_xadd_q2;
      r_din_q1  <= bus.xdata_in; r_din_q2  <= r_din_q1;   r_din_q3  <= r_din_q2;
    end
  end

  // Edges are ignored until all three stages hold real pin samples, and a write
  // only commits after wen has been seen idle-high, so a strobe already active at
  // reset release can never start a read or commit a write.
  always_ff @(posedge clk) begin
    if (global_rst) begin
      r_settle  <= 2'd0;
      r_wen_arm <= 1'b0;
    end else begin
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd3 && r_wen_q2) r_wen_arm <= 1'b1;
    end
  end

  logic w_rd_start, w_wr_commit;
  assign w_rd_start  = (r_settle == 2'd3) && r_ren_q3 && !r_ren_q2;
  assign w_wr_commit = r_wen_arm && !r_wen_q3 && r_wen_q2;

  logic [ADDR_W-1:0] w_rd_off, w_wr_off;
  logic              w_rd_hit, w_wr_hit;
  assign w_rd_off = r_xadd_q2 - RD_BASE;
  assign w_rd_hit = (r_xadd_q2 >= RD_BASE) && (w_rd_off < ADDR_W'(NUM_RD));
  assign w_wr_off = r_xadd_q3 - WR_BASE;
  assign w_wr_hit = (r_xadd_q3 >= WR_BASE) && (w_wr_off < ADDR_W'(NUM_WR));

  logic [DATA_W-1:0] w_rd_sel;
  always_comb begin
    w_rd_sel = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_rd_off == ADDR_W'(k)) w_rd_sel = rd_data[k*DATA_W +: DATA_W];
    end
  end

  logic              w_rd_map;
  logic [DATA_W-1:0] w_rd_val;
`ifdef XINTF_WR_READBACK_EN
  logic [ADDR_W-1:0] w_rb_off;
  logic              w_rb_hit;
  logic [DATA_W-1:0] w_rb_sel;
  assign w_rb_off = r_xadd_q2 - WR_BASE;
  assign w_rb_hit = (r_xadd_q2 >= WR_BASE) && (w_rb_off < ADDR_W'(NUM_WR));
  always_comb begin
    w_rb_sel = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (w_rb_off == ADDR_W'(k)) w_rb_sel = r_wr_data[k*DATA_W +: DATA_W];
    end
  end
  assign w_rd_map = w_rd_hit || w_rb_hit;
  assign w_rd_val = w_rd_hit ? w_rd_sel : w_rb_sel;
`else
  assign w_rd_map = w_rd_hit;
  assign w_rd_val = w_rd_sel;
`endif

  always_ff @(posedge clk) begin
    if (global_rst) begin
      r_state     <= S_IDLE;
      r_xdata_out <= '0;
      r_xdata_oe  <= 1'b0;
      r_wr_data   <= '0;
      r_wr_pulse  <= '0;
      r_bad_cnt   <= 8'd0;
    end else begin
      r_wr_pulse <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_rd_start && w_rd_map) begin
            r_state     <= S_READ;
            r_xdata_out <= w_rd_val;
            r_xdata_oe  <= 1'b1;
          end
        end
        S_READ: begin
          if (r_ren_q2) begin
            r_state    <= S_IDLE;
            r_xdata_oe <= 1'b0;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_ren_q2) begin
            r_state    <= S_IDLE;
            r_xdata_oe <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_xdata_oe <= 1'b0;
        end
      endcase

      if (w_rd_start && !w_rd_map && r_bad_cnt != 8'hFF) r_bad_cnt <= r_bad_cnt + 8'd1;

      // A read holding the bus (ren_q2 low) discards any concurrent write silently.
      if (w_wr_commit && r_ren_q2) begin
        if (w_wr_hit) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (w_wr_off == ADDR_W'(k)) begin
              r_wr_data[k*DATA_W +: DATA_W] <= r_din_q3;
              r_wr_pulse[k]                 <= 1'b1;
            end
          end
        end else if (r_bad_cnt != 8'hFF) begin
          r_bad_cnt <= r_bad_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.xdata_out = r_xdata_out;
  assign bus.xdata_oe  = r_xdata_oe;
  assign wr_data       = r_wr_data;
  assign wr_pulse      = r_wr_pulse;
  assign bad_addr_cnt  = r_bad_cnt;

endmodule

`default_nettype wire

// File: doc/xintf_regbank.md
XINTF_REGBANK -- requirements
Module: xintf_regbank

Interface
REQ-001 Parameter NUM_RD, default 4, number of FPGA-to-DSP read channels (1..16).
REQ-002 Parameter NUM_WR, default 4, number of DSP-to-FPGA write channels (1..16).
REQ-003 Parameter DATA_W, default 16; parameter ADDR_W, default 20.
REQ-004 Parameter RD_BASE, default 20'h0FC01, address of read channel 0; parameter WR_BASE, default 20'h0FC05, address of write channel 0.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 global_rst  in  1  reset; synchronous and active-high.
REQ-007 ren  in  1  DSP read strobe, active-low, asynchronous to clk.
REQ-008 wen  in  1  DSP write strobe, active-low, asynchronous to clk.
REQ-009 xadd  in  ADDR_W  DSP address, asynchronous.
REQ-010 xdata_in  in  DATA_W  DSP data bus input side.
REQ-011 xdata_out  out  DATA_W  read data to pad; xdata_oe  out  1  pad tristate enable, active-high.
REQ-012 rd_data  in  NUM_RD*DATA_W  flat read channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-013 wr_data  out  NUM_WR*DATA_W  flat write registers, same packing.
REQ-014 wr_pulse  out  NUM_WR  one-cycle pulse per channel when its register is updated.
REQ-015 bad_addr_cnt  out  8  saturating count of strobes to unmapped addresses.

Function
REQ-016 ren, wen, xadd, xdata_in shall each pass a 2-flop synchronizer (stage q1, q2) plus one history stage q3.
REQ-017 Read start = falling edge of synchronized ren (ren_q3=1, ren_q2=0); write commit = rising edge of synchronized wen (wen_q3=0, wen_q2=1).
REQ-018 On read start with xadd_q2 in [RD_BASE, RD_BASE+NUM_RD-1], channel (xadd_q2-RD_BASE) of rd_data shall be snapshot into xdata_out on the next clock and xdata_oe set to 1.
REQ-019 xdata_out shall stay frozen and xdata_oe stay 1 while ren_q2=0; xdata_oe shall drop to 0 on the clock after ren_q2 returns to 1.
REQ-020 On write commit with xadd_q3 in [WR_BASE, WR_BASE+NUM_WR-1], channel (xadd_q3-WR_BASE) of wr_data shall load xdata_in_q3 on the next clock, with its wr_pulse bit high for exactly that cycle.
REQ-021 Total latency pin-wen-rise to wr_data update: 4 clocks max; pin-ren-fall to xdata_oe=1: 4 clocks max.
REQ-022 Read or write start to an unmapped address: no register change, xdata_oe stays 0, bad_addr_cnt increments by 1, saturating at 8'hFF.
REQ-023 ren_q2=0 and write commit in the same cycle: read wins, write discarded, bad_addr_cnt unchanged.
REQ-024 RD and WR windows overlapping: configuration error; behaviour undefined, not verified.
REQ-025 State machine states IDLE, READ (driving), HOLD (wait ren_q2 high then drop oe); IDLE->READ on valid read start, READ->IDLE when ren_q2=1.
REQ-026 At most one wr_pulse bit high in any cycle.

Reset
REQ-027 While global_rst=1 at a clock edge: all synchronizer stages to 1 for ren/wen and 0 for xadd/xdata_in, wr_data=0, wr_pulse=0, xdata_out=0, xdata_oe=0, bad_addr_cnt=0, state IDLE.
REQ-028 Reset asserted mid-read shall drop xdata_oe on the same edge; a strobe in progress at reset release shall not produce a read start or write commit.

Configuration
REQ-029 Macro XINTF_WR_READBACK_EN defined: a read start addressing the WR window shall return the current wr_data channel and count as mapped; undefined: WR-window reads count as unmapped per REQ-022.

Verification
REQ-030 Write 16'hA5A5 to 20'h0FC06 -> wr_data channel 1 = 16'hA5A5 within 4 clocks of wen rise, wr_pulse=4'b0010 for one cycle.
REQ-031 rd_data ch2=16'h1234, ren low at 20'h0FC03, ch2 changes to 16'h5678 mid-strobe -> xdata_out stays 16'h1234, xdata_oe=1 until 1 clock after ren_q2 high.
REQ-032 Write to 20'h0FC20, then 300 unmapped reads -> no wr_pulse, xdata_oe=0, bad_addr_cnt=8'hFF.
REQ-033 ren and wen both low, address 20'h0FC05 -> no wr_data change, no wr_pulse.
REQ-034 global_rst=1 during active read at 20'h0FC01 -> xdata_oe=0 next edge; all outputs zero.
REQ-035 With XINTF_WR_READBACK_EN, write 16'h00FF to 20'h0FC08 then read 20'h0FC08 -> xdata_out=16'h00FF; without it -> xdata_oe=0, bad_addr_cnt+1.
